spi_slave_word: RTL and testbench

Oversampling SPI slave front-end (mode 0, MSB first) for the FPGA application layer. Samples the asynchronous SSEL/SCK/MOSI pins in the system `clk` domain and assembles received bits into parallel words with a one-cycle valid strobe. Serializes a parallel response word onto MISO and hands upstream logic a request strobe whenever it captures the next transmit word. Downstream register/command logic consumes `rx_data`/`rx_valid` and supplies `tx_data`.

---
 rtl/spi_slave_word.sv | 139 +++++++++++++
 tb/tb_spi_slave_word.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_word.sv
// Oversampling mode-0 SPI slave (MSB first). Synchronizes SSEL/SCK/MOSI into clk and
// moves WIDTH-bit words between the SPI pins and a parallel strobe interface.
module spi_slave_word #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             SSEL,
    input  logic             SCK,
    input  logic             MOSI,
    output logic             MISO,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    input  logic [WIDTH-1:0] tx_data,
    output logic             tx_load,
    output logic             active
);
    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic       sck_s1_q, sck_s2_q, sck_s3_q;
    logic       ssel_s1_q, ssel_s2_q, ssel_s3_q;
    logic       mosi_s1_q, mosi_s2_q;
    logic [1:0] fill_q;

    logic             frame_q, frame_d;
    logic             armed_q, armed_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic [WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             miso_q, miso_d;
    logic             load_word;

    logic sck_rise, sck_fall, frame_start;

    // NOTE: every sequential block uses non-blocking assignments so all flops
    // sample the same pre-edge values; combinational next-state uses blocking.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sck_s1_q  <= 1'b0;
            sck_s2_q  <= 1'b0;
            sck_s3_q  <= 1'b0;
            ssel_s1_q <= 1'b1;
            ssel_s2_q <= 1'b1;
            ssel_s3_q <= 1'b0;
            mosi_s1_q <= 1'b0;
            mosi_s2_q <= 1'b0;
            fill_q    <= 2'b00;
        end else begin
            sck_s1_q  <= SCK;
            sck_s2_q  <= sck_s1_q;
            sck_s3_q  <= sck_s2_q;
            ssel_s1_q <= SSEL;
            ssel_s2_q <= ssel_s1_q;
            ssel_s3_q <= ssel_s2_q;
            mosi_s1_q <= MOSI;
            mosi_s2_q <= mosi_s1_q;
            fill_q    <= {fill_q[0], 1'b1};
        end
    end

    assign sck_rise    = ~sck_s3_q & sck_s2_q;
    assign sck_fall    = sck_s3_q & ~sck_s2_q;
    // A frame may only start after SSEL has really been seen high since reset;
    // fill_q marks when ssel_s2_q holds a pin sample rather than its reset value.
    assign frame_start = armed_q & ssel_s3_q & ~ssel_s2_q;

    // NOTE: every variable gets a default at the top so no path infers a latch.
    always_comb begin
        frame_d    = frame_q;
        armed_d    = armed_q | (fill_q[1] & ssel_s2_q);
        bit_cnt_d  = bit_cnt_q;
        rx_shift_d = rx_shift_q;
        tx_shift_d = tx_shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        load_word  = 1'b0;

        if (ssel_s2_q) begin
            frame_d   = 1'b0;
            bit_cnt_d = '0;
        end else if (frame_start) begin
            frame_d    = 1'b1;
            bit_cnt_d  = '0;
            rx_shift_d = '0;
            tx_shift_d = tx_data;
            load_word  = 1'b1;
        end else if (frame_q) begin
            if (sck_rise) begin
                rx_shift_d = {rx_shift_q[WIDTH-2:0], mosi_s2_q};
                if (bit_cnt_q == LAST_BIT) begin
                    bit_cnt_d  = '0;
                    rx_data_d  = {rx_shift_q[WIDTH-2:0], mosi_s2_q};
                    rx_valid_d = 1'b1;
                    tx_shift_d = tx_data;
                    load_word  = 1'b1;
                end else begin
                    bit_cnt_d = bit_cnt_q + CW'(1);
                end
            end else if (sck_fall && bit_cnt_q != '0) begin
                // At a word boundary the fresh MSB must stay on MISO, so no shift.
                tx_shift_d = tx_shift_q << 1;
            end
        end

        miso_d = frame_d ? tx_shift_d[WIDTH-1] : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            frame_q    <= 1'b0;
            armed_q    <= 1'b0;
            bit_cnt_q  <= '0;
            rx_shift_q <= '0;
            tx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            miso_q     <= 1'b0;
        end else begin
            frame_q    <= frame_d;
            armed_q    <= armed_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_shift_q <= rx_shift_d;
            tx_shift_q <= tx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            miso_q     <= miso_d;
        end
    end

    assign MISO     = miso_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign tx_load  = load_word;
    assign active   = frame_q;

endmodule

// File: tb/tb_spi_slave_word.sv
// Directed bench for spi_slave_word: drives SPI frames at f_clk/8 and compares
// received words, strobes and MISO bits against a frame-level model.
module tb_spi_slave_word;
    localparam int W = 8;
    localparam int H = 4;  // clk periods per SCK phase

    logic         clk = 1'b0;
    logic         resetn, SSEL, SCK, MOSI;
    logic         MISO, rx_valid, tx_load, active;
    logic [W-1:0] rx_data, tx_data;

    int checks = 0, errors = 0;
    int rx_cnt = 0, tx_cnt = 0, exp_rx_cnt = 0, exp_tx_cnt = 0;
    logic [W-1:0] exp_q[$];
    bit idle_chk = 1'b0, frame_chk = 1'b0;
    bit prev_rx_valid = 1'b0, prev_tx_load = 1'b0;

    always #5 clk = ~clk;

    spi_slave_word #(.WIDTH(W)) dut (
        .clk     (clk),
        .resetn  (resetn),
        .SSEL    (SSEL),
        .SCK     (SCK),
        .MOSI    (MOSI),
        .MISO    (MISO),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .tx_data (tx_data),
        .tx_load (tx_load),
        .active  (active)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, wanted 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Model: each completed word inside a frame yields one rx event; each frame
    // start and each completed word yields one tx load; idle means MISO/active low.
    always @(negedge clk) begin
        if (rx_valid) begin
            rx_cnt++;
            check("rx_valid_single", prev_rx_valid, 0);
            if (exp_q.size() == 0) check("rx_valid_unexpected", 1, 0);
            else check("rx_data", rx_data, exp_q.pop_front());
        end
        if (tx_load) begin
            tx_cnt++;
            check("tx_load_single", prev_tx_load, 0);
        end
        if (idle_chk) begin
            check("idle_active", active, 0);
            check("idle_miso", MISO, 0);
        end
        if (frame_chk) check("frame_active", active, 1);
        prev_rx_valid = rx_valid;
        prev_tx_load  = tx_load;
    end

    task automatic start_frame();
        idle_chk = 1'b0;
        SSEL = 1'b0;
        exp_tx_cnt++;
        tick(4);
        frame_chk = 1'b1;
    endtask

    task automatic end_frame();
        frame_chk = 1'b0;
        SSEL = 1'b1;
        tick(4);
        idle_chk = 1'b1;
        tick(4);
    endtask

    task automatic send_word(input logic [W-1:0] rx_b, input logic [W-1:0] tx_b,
                             input int nbits, input logic [W-1:0] next_tx, input bit desel_last);
        for (int i = 0; i < nbits; i++) begin
            MOSI = rx_b[W-1-i];
            tick(H);
            check("miso_bit", MISO, tx_b[W-1-i]);
            if (i == nbits - 1) begin
                if (desel_last) begin
                    frame_chk = 1'b0;
                    SSEL = 1'b1;
                end else if (nbits == W) begin
                    exp_q.push_back(rx_b);
                    exp_rx_cnt++;
                    exp_tx_cnt++;
                end
            end
            SCK = 1'b1;
            if (i == 0) tx_data = next_tx;
            tick(H);
            SCK = 1'b0;
        end
    endtask

    task automatic sck_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            SCK = 1'b1;
            tick(H);
            SCK = 1'b0;
            tick(H);
        end
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_rx_count"}, rx_cnt, exp_rx_cnt);
        check({tag, "_tx_count"}, tx_cnt, exp_tx_cnt);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; SSEL = 1'b0; SCK = 1'b0; MOSI = 1'b0; tx_data = 8'hA5;
        tick(5);
        check("reset_miso", MISO, 0);
        check("reset_rx_data", rx_data, 0);
        check("reset_rx_valid", rx_valid, 0);
        check("reset_tx_load", tx_load, 0);
        check("reset_active", active, 0);

        // SSEL held low through reset: no frame until it toggles
        resetn = 1'b1;
        idle_chk = 1'b1;
        tick(12);
        sck_pulses(3);
        check("no_false_start", tx_cnt, 0);
        SSEL = 1'b1;
        tick(6);
        sck_pulses(3);
        check_counts("deselected");

        // Single word: MOSI 0x3C, MISO 0xA5
        start_frame();
        send_word(8'h3C, 8'hA5, W, 8'hA5, 1'b0);
        end_frame();
        check("s1_rx_data", rx_data, 8'h3C);
        check_counts("s1");

        // Back-to-back words, tx_data switched after the first load
        start_frame();
        send_word(8'h01, 8'hA5, W, 8'h81, 1'b0);
        send_word(8'hFE, 8'h81, W, 8'h81, 1'b0);
        end_frame();
        check("s2_rx_data", rx_data, 8'hFE);
        check_counts("s2");

        // Partial word discarded, next frame starts clean
        start_frame();
        send_word(8'hB7, 8'h81, 5, 8'h81, 1'b0);
        end_frame();
        check("s3_partial_rx_data", rx_data, 8'hFE);
        start_frame();
        send_word(8'hFF, 8'h81, W, 8'h81, 1'b0);
        end_frame();
        check("s3_rx_data", rx_data, 8'hFF);
        check_counts("s3");

        // Deselect coincident with the word-completing SCK rise
        start_frame();
        send_word(8'h6A, 8'h81, W, 8'h81, 1'b1);
        tick(4);
        idle_chk = 1'b1;
        tick(4);
        check("s4_rx_data_held", rx_data, 8'hFF);
        check("s4_miso", MISO, 0);
        check("s4_active", active, 0);
        check_counts("s4");

        // Reset mid-frame, SSEL still low, then a fresh frame
        tx_data = 8'h3C;
        start_frame();
        send_word(8'h55, 8'h3C, 4, 8'h3C, 1'b0);
        frame_chk = 1'b0;
        resetn = 1'b0;
        tick(3);
        check("s5_reset_rx_data", rx_data, 0);
        check("s5_reset_active", active, 0);
        resetn = 1'b1;
        idle_chk = 1'b1;
        tick(12);
        check("s5_no_start_after_reset", tx_cnt, exp_tx_cnt);
        SSEL = 1'b1;
        tick(6);
        start_frame();
        send_word(8'h55, 8'h3C, W, 8'h3C, 1'b0);
        end_frame();
        check("s5_rx_data", rx_data, 8'h55);
        check_counts("s5");

        tick(10);
        check("final_rx_pulses", rx_cnt, 5);
        check("final_tx_pulses", tx_cnt, 12);
        check("final_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
